mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 30, word address width of the shared memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request; held with if_addr stable until if_gnt.
REQ-006 if_addr  input  ADDR_W  fetch word address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch read data valid this cycle.
REQ-009 if_rdata  output  DATA_W  fetch read data.
REQ-010 d_req  input  1  data-port request; held with d_we, d_addr and d_wdata stable until d_gnt.
REQ-011 d_we  input  1  data request is a write (1) or a read (0).
REQ-012 d_addr  input  ADDR_W  data word address.
REQ-013 d_wdata  input  DATA_W  data write value.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  data read data valid this cycle; never asserted for writes.
REQ-016 d_rdata  output  DATA_W  data read value.
REQ-017 mem_addr  output  ADDR_W  shared memory address.
REQ-018 mem_wdata  output  DATA_W  shared memory write data.
REQ-019 mem_wren  output  1  memory write enable.
REQ-020 mem_rren  output  1  memory read enable.
REQ-021 mem_E  output  1  memory enable; driven 1 whenever not in reset.
REQ-022 mem_rdata  input  DATA_W  registered memory output, valid the cycle after mem_rren.

Function
REQ-023 Grant decision is combinational from the current-cycle requests: at most one of if_gnt and d_gnt is 1 per cycle; neither is 1 without its req.
REQ-024 A lone requester is granted in the same cycle it asserts req.
REQ-025 When both requesters are pending, data wins unless last_gnt==DATA, in which case fetch wins; last_gnt updates on every grant.
REQ-026 In a granted cycle, mem_addr, mem_wdata, mem_wren (d_we for data, 0 for fetch) and mem_rren (!d_we for data, 1 for fetch) come from the winner.
REQ-027 In a cycle with no grant, mem_wren=0 and mem_rren=0; mem_addr and mem_wdata hold their last driven values.
REQ-028 Read latency is exactly 1 cycle: a read granted in cycle N gives rvalid=1 to its owner in cycle N+1, with rdata=mem_rdata.
REQ-029 The response owner register (NONE/IF/D) is loaded on each read grant, otherwise loaded with NONE.
REQ-030 Back-to-back accesses are allowed: a new grant may occur in the same cycle as the previous read's rvalid.
REQ-031 if_rdata and d_rdata carry mem_rdata only in their valid cycle, and are 0 otherwise.
REQ-032 A write completes at the posedge ending its grant cycle; a read to the same address granted in the next cycle returns the new value.

Reset
REQ-033 While rst=1: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wren, mem_rren and mem_E are 0; mem_addr, mem_wdata, if_rdata and d_rdata are 0.
REQ-034 Reset sets owner to NONE and last_gnt to IF, so data wins the first contention.
REQ-035 A read granted in the cycle before reset asserts produces no rvalid after reset releases.
REQ-036 Grants resume on the first posedge after rst deasserts.

Structure
REQ-037 Package mem_arb_pkg holds the owner enum (NONE, IF, D), the last_gnt enum (IF, DATA) and the ADDR_W/DATA_W defaults.
REQ-038 Sub-module mem_arb_pick is the 2-way alternating-priority picker: inputs are the two reqs and last_gnt, outputs are the two one-hot grants.
REQ-039 There are no other state elements beyond owner, last_gnt and the mem_addr/mem_wdata hold registers.

Verification
REQ-040 Scenario: reset, then if_req=1 with if_addr=0 and memory[0]=0x24020064 -> if_gnt in cycle 0; if_rvalid=1 with if_rdata=0x24020064 in cycle 1.
REQ-041 Scenario: d_req=1, d_we=1, d_addr=0x40, d_wdata=100, then a d_req read of 0x40 in the next cycle -> d_gnt in both cycles; d_rvalid only after the read, with d_rdata=100.
REQ-042 Scenario: if_req and d_req held together for 4 reads -> grants alternate D, IF, D, IF; each rvalid goes to the correct owner one cycle after its grant.
REQ-043 Scenario: fetch read granted, then rst pulsed in the next cycle -> if_rvalid stays 0 and all outputs are 0 during reset.
REQ-044 Scenario: continuous fetch stream at addresses 0..3 -> one grant per cycle; if_rvalid asserted for 4 consecutive cycles with the correct data in order.
REQ-045 Scenario: no requests for 3 cycles -> mem_wren=0, mem_rren=0, no gnt and no rvalid, with mem_addr held.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and width defaults for the instruction/data memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 30;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
  typedef enum logic {LG_IF, LG_DATA} last_gnt_e;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: 2-way alternating-priority picker; data wins contention unless it won last.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic      if_req,
  input  logic      d_req,
  input  last_gnt_e last_gnt,
  output logic      if_gnt,
  output logic      d_gnt
);
  always_comb begin
    d_gnt = d_req & (~if_req | (last_gnt != LG_DATA));
    if_gnt = if_req & ~d_gnt;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch port and a data port,
// with same-cycle grants and a fixed 1-cycle read response routed back to the requester.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rren,
  output logic              mem_E,
  input  logic [DATA_W-1:0] mem_rdata
);
  owner_e            owner_q, owner_d;
  last_gnt_e         last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              if_win, d_win;
  // Requests are masked in reset so no grant or memory strobe can escape.
  mem_arb_pick u_pick (
    .if_req  (if_req & ~rst),
    .d_req   (d_req & ~rst),
    .last_gnt(last_q),
    .if_gnt  (if_win),
    .d_gnt   (d_win)
  );
  always_comb begin
    if_gnt = if_win;
    d_gnt = d_win;
    mem_addr = d_win ? d_addr : if_win ? if_addr : addr_q;
    mem_wdata = d_win ? d_wdata : wdata_q;
    mem_wren = d_win & d_we;
    mem_rren = if_win | (d_win & ~d_we);
    mem_E = ~rst;
    owner_d = if_win ? OWN_IF : (d_win & ~d_we) ? OWN_D : OWN_NONE;
    if_rvalid = owner_q == OWN_IF;
    d_rvalid = owner_q == OWN_D;
    if_rdata = if_rvalid ? mem_rdata : '0;
    d_rdata = d_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      last_q <= LG_IF;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      last_q <= d_win ? LG_DATA : if_win ? LG_IF : last_q;
      addr_q <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end
endmodule
